// File: rtl/jk_count_sequencer.sv
// Excitation generator for a bank of sync-reset JK flip-flops. It keeps a shadow of the bank
// state and steps the bank through a modulo-p_MODULUS up/down count with parallel load.
module jk_count_sequencer #(
  parameter int p_WIDTH   = 4,
  parameter int p_MODULUS = 10
) (
  input  logic               i_CLOCK_POS,
  input  logic               i_RESET_NEG,
  input  logic               i_ENABLE,
  input  logic               i_UP_DOWN,
  input  logic               i_LOAD,
  input  logic [p_WIDTH-1:0] i_LOAD_VALUE,
  output logic [p_WIDTH-1:0] o_SIGNAL_J,
  output logic [p_WIDTH-1:0] o_SIGNAL_K,
  output logic [p_WIDTH-1:0] o_COUNT,
  output logic               o_TERMINAL,
  output logic               o_BANK_RESET_NEG
);

  generate
    if (p_MODULUS < 2 || p_MODULUS > (1 << p_WIDTH)) begin : g_bad_modulus
      $error("jk_count_sequencer: p_MODULUS out of range 2..2**p_WIDTH");
    end
  endgenerate

  localparam logic [p_WIDTH:0]   MOD_EXT = (p_WIDTH+1)'(p_MODULUS);
  localparam logic [p_WIDTH-1:0] CNT_MAX = p_WIDTH'(p_MODULUS - 1);

  logic [p_WIDTH-1:0] count_p1;
  logic               bank_rst_n_p1;
  logic [p_WIDTH-1:0] nxt_p0;
  logic               active;

  function automatic logic [p_WIDTH-1:0] sat_load(input logic [p_WIDTH-1:0] v);
    if ({1'b0, v} >= MOD_EXT) return CNT_MAX;
    return v;
  endfunction

  // The bank's clear is low both in reset and during the clear window, so it gates all activity.
  assign active = bank_rst_n_p1;

  // Stage p0: next-state, excitation and terminal count
  always_comb begin
    nxt_p0 = count_p1;
    if (active) begin
      if (i_LOAD) begin
        nxt_p0 = sat_load(i_LOAD_VALUE);
      end else if (i_ENABLE && i_UP_DOWN) begin
        nxt_p0 = (count_p1 == CNT_MAX) ? '0 : count_p1 + 1'b1;
      end else if (i_ENABLE) begin
        nxt_p0 = (count_p1 == '0) ? CNT_MAX : count_p1 - 1'b1;
      end
    end
  end

  assign o_SIGNAL_J = nxt_p0 & ~count_p1;
  assign o_SIGNAL_K = ~nxt_p0 & count_p1;
  assign o_TERMINAL = active & i_ENABLE & ~i_LOAD &
                      ((i_UP_DOWN & (count_p1 == CNT_MAX)) | (~i_UP_DOWN & (count_p1 == '0)));

  // Stage p1: shadow register and bank clear
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      count_p1      <= '0;
      bank_rst_n_p1 <= 1'b0;
    end else begin
      bank_rst_n_p1 <= 1'b1;
      if (active) count_p1 <= nxt_p0;
    end
  end

  assign o_COUNT          = count_p1;
  assign o_BANK_RESET_NEG = bank_rst_n_p1;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench for jk_count_sequencer with a behavioural JK bank driven from its outputs.
module tb_jk_count_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ud;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] sig_j;
  logic [3:0] sig_k;
  logic [3:0] count;
  logic       term;
  logic       bank_rst_n;
  logic [3:0] bank_q;

  int checks = 0;
  int errors = 0;

  jk_count_sequencer #(.p_WIDTH(4), .p_MODULUS(10)) dut (
    .i_CLOCK_POS      (clk),
    .i_RESET_NEG      (rst_n),
    .i_ENABLE         (en),
    .i_UP_DOWN        (ud),
    .i_LOAD           (load),
    .i_LOAD_VALUE     (load_val),
    .o_SIGNAL_J       (sig_j),
    .o_SIGNAL_K       (sig_k),
    .o_COUNT          (count),
    .o_TERMINAL       (term),
    .o_BANK_RESET_NEG (bank_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-reset JK bank, preset tied inactive
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!bank_rst_n) bank_q[b] <= 1'b0;
      else begin
        case ({sig_j[b], sig_k[b]})
          2'b10:   bank_q[b] <= 1'b1;
          2'b01:   bank_q[b] <= 1'b0;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; ud = 1'b1; load = 1'b0; load_val = 4'd0;
    tick(); tick();

    // Release with a load pending: the clear window must ignore it
    rst_n = 1'b1; load = 1'b1; load_val = 4'd5;
    #1;
    chk("clr_bank_rst", 32'(bank_rst_n), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_j", 32'(sig_j), 32'd0);
    chk("clr_k", 32'(sig_k), 32'd0);
    chk("clr_term", 32'(term), 32'd0);
    tick();
    chk("post_clr_bank_rst", 32'(bank_rst_n), 32'd1);
    chk("post_clr_count", 32'(count), 32'd0);
    chk("load5_j", 32'(sig_j), 32'd5);
    tick();
    chk("load5_count", 32'(count), 32'd5);

    // Asynchronous reset mid-cycle
    en = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_bank_rst", 32'(bank_rst_n), 32'd0);
    chk("async_j", 32'(sig_j), 32'd0);
    chk("async_term", 32'(term), 32'd0);
    tick();
    rst_n = 1'b1; load = 1'b0;
    tick();
    chk("rel2_bank_rst", 32'(bank_rst_n), 32'd1);
    chk("rel2_count", 32'(count), 32'd0);

    // Up count with wrap
    en = 1'b1; ud = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      chk("up_count", 32'(count), 32'(i % 10));
      chk("up_term", 32'(term), 32'(i == 9));
      if (i == 9) begin
        chk("up9_j", 32'(sig_j), 32'h0);
        chk("up9_k", 32'(sig_k), 32'h9);
      end
      tick();
    end
    // count is now 1; load 0 to start the down test
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; ud = 1'b0;
    #1;
    chk("dn0_count", 32'(count), 32'd0);
    chk("dn0_term", 32'(term), 32'd1);
    chk("dn0_j", 32'(sig_j), 32'h9);
    chk("dn0_k", 32'(sig_k), 32'h0);
    tick();
    chk("dn9_count", 32'(count), 32'd9);
    chk("dn9_term", 32'(term), 32'd0);
    tick();
    chk("dn8_count", 32'(count), 32'd8);

    // Up to 9, then load over a terminal condition with saturation
    ud = 1'b1;
    tick();
    chk("pre_load_count", 32'(count), 32'd9);
    load = 1'b1; load_val = 4'd13;
    #1;
    chk("load_term", 32'(term), 32'd0);
    chk("load13_j", 32'(sig_j), 32'd0);
    tick();
    chk("load13_count", 32'(count), 32'd9);
    load_val = 4'd3;
    #1;
    chk("load3_j", 32'(sig_j), 32'h2);
    chk("load3_k", 32'(sig_k), 32'h8);
    tick();
    chk("load3_count", 32'(count), 32'd3);
    load_val = 4'd10;
    tick();
    chk("load10_count", 32'(count), 32'd9);

    // Hold at 6
    load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ud = 1'(i & 1);
      #1;
      chk("hold_count", 32'(count), 32'd6);
      chk("hold_j", 32'(sig_j), 32'd0);
      chk("hold_k", 32'(sig_k), 32'd0);
      chk("hold_term", 32'(term), 32'd0);
      tick();
    end
    chk("hold_end_count", 32'(count), 32'd6);

    // Bank co-simulation under random stimulus with one mid-run reset
    for (int c = 0; c < 1000; c++) begin
      if (bank_rst_n) chk("bank_eq", 32'(bank_q), 32'(count));
      en = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      if (c == 500) begin
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        tick();
        rst_n = 1'b1;
      end
      #1;
      if (bank_rst_n) chk("no_jk11", 32'(sig_j & sig_k), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_count_sequencer.md
Name: jk_count_sequencer

Overview:
- Upstream excitation stage for a bank of p_WIDTH synchronous JK flip-flops (J, K, sync active-low preset/reset per bit, posedge clock).
- Each cycle it computes the J/K pair per bit so that the bank steps through a modulo-p_MODULUS up/down count with parallel load.
- It keeps an internal shadow of the bank state for next-state and terminal-count logic.
- It also generates the bank's synchronous clear after an asynchronous reset, so the bank and the shadow leave reset in lockstep.

Parameters:
- p_WIDTH, 4, bit width of the count, shadow and J/K vectors.
- p_MODULUS, 10, count modulus; legal range 2..2^p_WIDTH. Values outside that range are a configuration error and must be flagged by an elaboration-time check.

Ports:
- i_CLOCK_POS  in  1  clock; all state updates on its rising edge.
- i_RESET_NEG  in  1  asynchronous active-low reset.
- i_ENABLE  in  1  count enable.
- i_UP_DOWN  in  1  direction: 1 = up, 0 = down.
- i_LOAD  in  1  parallel load request; takes priority over i_ENABLE.
- i_LOAD_VALUE  in  p_WIDTH  value to load.
- o_SIGNAL_J  out  p_WIDTH  J excitation per bank bit.
- o_SIGNAL_K  out  p_WIDTH  K excitation per bank bit.
- o_COUNT  out  p_WIDTH  registered shadow of the bank state.
- o_TERMINAL  out  1  terminal-count indication (combinational).
- o_BANK_RESET_NEG  out  1  registered active-low synchronous clear for the bank's reset inputs.

Behaviour:
- Reset (i_RESET_NEG low, asynchronous):
  - o_COUNT = 0 and o_BANK_RESET_NEG = 0 immediately, independent of the clock.
  - o_SIGNAL_J = 0, o_SIGNAL_K = 0, o_TERMINAL = 0.
- Reset release, clear window:
  - o_BANK_RESET_NEG rises on the first rising edge with i_RESET_NEG high. Call the cycle before that edge the clear window.
  - On that edge the bank sees its sync reset low and clears to 0.
  - During the clear window: o_COUNT holds 0, i_LOAD and i_ENABLE are ignored, J = K = 0, o_TERMINAL = 0.
- Next-state (nxt) outside the clear window:
  - If i_LOAD = 1: nxt = i_LOAD_VALUE, saturated to p_MODULUS-1 when i_LOAD_VALUE >= p_MODULUS.
  - Else if i_ENABLE = 1 and i_UP_DOWN = 1: nxt = 0 when o_COUNT == p_MODULUS-1, otherwise o_COUNT+1.
  - Else if i_ENABLE = 1 and i_UP_DOWN = 0: nxt = p_MODULUS-1 when o_COUNT == 0, otherwise o_COUNT-1.
  - Otherwise: nxt = o_COUNT.
  - All arithmetic is p_WIDTH bits. Wrap is by compare to the modulus, never by natural overflow, except when p_MODULUS = 2^p_WIDTH, where the two coincide.
- Shadow update: o_COUNT <= nxt on each rising edge outside the clear window. Latency from input to bank state and to o_COUNT is 1 cycle.
- Excitation (combinational from o_COUNT and nxt), per bit i:
  - o_SIGNAL_J[i] = nxt[i] & ~o_COUNT[i]
  - o_SIGNAL_K[i] = ~nxt[i] & o_COUNT[i]
  - J = K = 1 is never produced; hold is always 00.
- Terminal count: o_TERMINAL = i_ENABLE & ~i_LOAD & ((i_UP_DOWN & o_COUNT == p_MODULUS-1) | (~i_UP_DOWN & o_COUNT == 0)). It is 0 during the clear window.
- Simultaneous events:
  - i_LOAD with i_ENABLE: load wins; o_TERMINAL = 0.
  - A direction change takes effect on the same cycle.
- Reset mid-operation: asynchronous return to the reset values above, then a fresh clear window. No partial count survives reset.
- Invariant: after the clear window, the bank Q equals o_COUNT after every edge, given a bank of sync-reset JK flip-flops whose reset has priority over J/K.

Test Plan:
- Reset and clear window: assert i_RESET_NEG low mid-cycle, then release with i_LOAD = 1 and i_LOAD_VALUE = 5 in the first cycle. Required: outputs go to reset values without waiting for an edge. o_BANK_RESET_NEG = 0 until the first edge, then 1. The load is ignored and o_COUNT stays 0 after that first edge.
- Up count wrap (p_MODULUS = 10), i_ENABLE = 1, i_UP_DOWN = 1 from 0. Required: o_COUNT runs 0..9, 0. o_TERMINAL = 1 only while o_COUNT = 9. At 9, J = 0000 and K = 1001.
- Down count wrap from 0, i_UP_DOWN = 0. Required: o_COUNT goes 0 -> 9 -> 8. o_TERMINAL = 1 at 0. J = 1001 and K = 0000 on the 0 -> 9 step.
- Load priority and saturation: i_LOAD = 1, i_ENABLE = 1, i_LOAD_VALUE = 13. Required: o_COUNT = 9 next cycle and o_TERMINAL = 0 during the load cycle. Then i_LOAD_VALUE = 3 gives o_COUNT = 3.
- Bank co-simulation: drive a 4-bit bank of sync-reset JK flip-flops from o_SIGNAL_J, o_SIGNAL_K and o_BANK_RESET_NEG (preset tied high). Apply a random mix of enable, load and direction for 1000 cycles, with one asynchronous reset in the middle. Required: bank Q == o_COUNT on every cycle after each clear window, and {J,K} = 11 never occurs.
- Hold: i_ENABLE = 0, i_LOAD = 0 at o_COUNT = 6 for 5 cycles. Required: o_COUNT stays 6, J = K = 0000, o_TERMINAL = 0.
